// File: rtl/pwl_add3_gain_sched.sv
// Gain scheduler for a 3-input adder: ramps scale1..3 linearly to a new target over NSTEP edges.
// Latency: scales move on the NSTEP edges after a transfer; done pulses the cycle after the last one.
// Backpressure: req_ready is low while ramping, frozen or in reset; requests are never queued.
module pwl_add3_gain_sched #(
    parameter int  NSTEP = 8,
    parameter real INIT1 = 1.0,
    parameter real INIT2 = 1.0,
    parameter real INIT3 = 1.0
) (
    input  logic clk,
    input  logic rstn,
    input  logic req_valid,
    output logic req_ready,
    input  real  tgt1,
    input  real  tgt2,
    input  real  tgt3,
    input  logic freeze,
    input  logic abort,
    output real  scale1,
    output real  scale2,
    output real  scale3,
    output logic enable,
    output logic busy,
    output logic done
);

    if (NSTEP < 1 || NSTEP > 256) begin : g_nstep_chk
        $fatal(1, "pwl_add3_gain_sched: NSTEP must be in 1..256");
    end

    localparam logic [8:0] CNT_LOAD = 9'(NSTEP);
    localparam real        NSTEP_R  = real'(NSTEP);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t     state, state_nxt;
    logic [8:0] cnt;
    logic       xfer, step_en, fin;
    real        lat1, lat2, lat3;
    real        step1, step2, step3;

    assign req_ready = rstn && (state == IDLE) && !freeze;
    assign busy      = (state == RAMP);

    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        step_en   = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    xfer      = 1'b1;
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                // abort outranks freeze; the last step lands on the latched target exactly
                if (abort || (!freeze && cnt == 9'd1)) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else if (!freeze) begin
                    step_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            scale1 <= INIT1;
            scale2 <= INIT2;
            scale3 <= INIT3;
            lat1   <= 0.0;
            lat2   <= 0.0;
            lat3   <= 0.0;
            step1  <= 0.0;
            step2  <= 0.0;
            step3  <= 0.0;
            enable <= 1'b1;
            done   <= 1'b0;
        end else begin
            enable <= !freeze;
            done   <= fin;
            if (xfer) begin
                lat1  <= tgt1;
                lat2  <= tgt2;
                lat3  <= tgt3;
                step1 <= (tgt1 - scale1) / NSTEP_R;
                step2 <= (tgt2 - scale2) / NSTEP_R;
                step3 <= (tgt3 - scale3) / NSTEP_R;
                cnt   <= CNT_LOAD;
            end else if (fin) begin
                scale1 <= lat1;
                scale2 <= lat2;
                scale3 <= lat3;
                cnt    <= '0;
            end else if (step_en) begin
                scale1 <= scale1 + step1;
                scale2 <= scale2 + step2;
                scale3 <= scale3 + step3;
                cnt    <= cnt - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_pwl_add3_gain_sched.sv
// Randomized and directed bench for pwl_add3_gain_sched; a closed-form ramp model feeds a per-cycle
// scoreboard queue that a negedge monitor drains. A second NSTEP=1 instance gets a short directed run.
module tb_pwl_add3_gain_sched;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, req_valid, freeze, abort;
    real  tgt1, tgt2, tgt3;
    logic req_ready, enable, busy, done;
    real  scale1, scale2, scale3;

    logic req_valid_b;
    real  tb1, tb2, tb3;
    logic req_ready_b, enable_b, busy_b, done_b;
    real  sb1, sb2, sb3;

    int vectors     = 0;
    int miscompares = 0;

    pwl_add3_gain_sched #(.NSTEP(N)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .tgt1(tgt1), .tgt2(tgt2), .tgt3(tgt3), .freeze(freeze), .abort(abort),
        .scale1(scale1), .scale2(scale2), .scale3(scale3),
        .enable(enable), .busy(busy), .done(done)
    );

    pwl_add3_gain_sched #(.NSTEP(1)) dut_b (
        .clk(clk), .rstn(rstn), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .tgt1(tb1), .tgt2(tb2), .tgt3(tb3), .freeze(1'b0), .abort(1'b0),
        .scale1(sb1), .scale2(sb2), .scale3(sb3),
        .enable(enable_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk_r(input string name, input real act, input real exp, input real tol);
        vectors++;
        if (act > exp + tol || act < exp - tol) begin
            miscompares++;
            $display("FAIL %s: got %0.9f expected %0.9f at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: after k active steps a scale sits at base + k*(tgt-base)/N, and at tgt when k==N.
    real m_s[0:2], m_base[0:2], m_tgt[0:2];
    int  m_k;
    bit  m_busy, m_done;
    real q_s1[$], q_s2[$], q_s3[$];
    bit  q_busy[$], q_done[$], q_en[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_s    = '{1.0, 1.0, 1.0};
            m_busy = 1'b0;
            m_k    = 0;
            q_s1.delete(); q_s2.delete(); q_s3.delete();
            q_busy.delete(); q_done.delete(); q_en.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (req_valid && !freeze) begin
                    m_base = m_s;
                    m_tgt  = '{tgt1, tgt2, tgt3};
                    m_k    = 0;
                    m_busy = 1'b1;
                end
            end else if (abort) begin
                m_s    = m_tgt;
                m_busy = 1'b0;
                m_done = 1'b1;
            end else if (!freeze) begin
                m_k++;
                if (m_k == N) begin
                    m_s    = m_tgt;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    for (int i = 0; i < 3; i++)
                        m_s[i] = m_base[i] + real'(m_k) * (m_tgt[i] - m_base[i]) / real'(N);
                end
            end
            q_s1.push_back(m_s[0]); q_s2.push_back(m_s[1]); q_s3.push_back(m_s[2]);
            q_busy.push_back(m_busy); q_done.push_back(m_done); q_en.push_back(!freeze);
        end
    end

    real e1, e2, e3, tol;
    bit  eb, ed, ee;

    always @(negedge clk) begin
        if (!rstn) begin
            chk_r("rst_scale1", scale1, 1.0, 0.0);
            chk_r("rst_scale2", scale2, 1.0, 0.0);
            chk_r("rst_scale3", scale3, 1.0, 0.0);
            chk_b("rst_busy", busy, 1'b0);
            chk_b("rst_done", done, 1'b0);
            chk_b("rst_enable", enable, 1'b1);
            chk_b("rst_req_ready", req_ready, 1'b0);
        end else if (q_s1.size() > 0) begin
            e1 = q_s1.pop_front(); e2 = q_s2.pop_front(); e3 = q_s3.pop_front();
            eb = q_busy.pop_front(); ed = q_done.pop_front(); ee = q_en.pop_front();
            tol = ed ? 0.0 : 1.0e-9;
            chk_r("scale1", scale1, e1, tol);
            chk_r("scale2", scale2, e2, tol);
            chk_r("scale3", scale3, e3, tol);
            chk_b("busy", busy, eb);
            chk_b("done", done, ed);
            chk_b("enable", enable, ee);
            chk_b("req_ready", req_ready, !eb && !freeze);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tgt(input real a, input real b, input real c);
        tgt1 = a; tgt2 = b; tgt3 = c;
    endtask

    function automatic real rnd_gain();
        return real'(int'($urandom_range(0, 16000)) - 8000) / 1000.0;
    endfunction

    initial begin
        rstn = 1'b1; req_valid = 1'b0; freeze = 1'b0; abort = 1'b0;
        set_tgt(0.0, 0.0, 0.0);
        req_valid_b = 1'b0; tb1 = 0.0; tb2 = 0.0; tb3 = 0.0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Basic ramp 1.0 -> (2,0,-1)
        set_tgt(2.0, 0.0, -1.0); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();

        // Ramp back to 1.0 with a 3-cycle freeze after the second step
        set_tgt(1.0, 1.0, 1.0); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        freeze = 1'b1;
        repeat (3) tick();
        freeze = 1'b0;
        repeat (4) tick();

        // Abort after the first step
        set_tgt(2.0, 0.0, -1.0); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();

        // Asynchronous reset between edges in the middle of a ramp
        set_tgt(-3.0, 4.0, 0.5); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #1 rstn = 1'b0;
        #1;
        chk_r("async_rst_scale1", scale1, 1.0, 0.0);
        chk_r("async_rst_scale2", scale2, 1.0, 0.0);
        chk_r("async_rst_scale3", scale3, 1.0, 0.0);
        chk_b("async_rst_busy", busy, 1'b0);
        chk_b("async_rst_done", done, 1'b0);
        #1 rstn = 1'b1;

        // Held request: second target only taken once the first ramp ends; target changes mid-ramp ignored
        set_tgt(2.0, 0.0, -1.0); req_valid = 1'b1;
        tick();
        set_tgt(0.5, 0.5, 0.5);
        repeat (12) tick();
        req_valid = 1'b0;
        repeat (2) tick();

        // Target equal to current scales still takes N steps
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            freeze    = ($urandom_range(0, 4) == 0);
            abort     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) set_tgt(m_s[0], m_s[1], m_s[2]);
            else set_tgt(rnd_gain(), rnd_gain(), rnd_gain());
            tick();
        end
        req_valid = 1'b0; freeze = 1'b0; abort = 1'b0;
        repeat (8) tick();

        // NSTEP=1 instance: equal target, then a real jump written at the first edge
        tb1 = 1.0; tb2 = 1.0; tb3 = 1.0; req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        chk_b("n1_busy_e0", busy_b, 1'b1);
        chk_b("n1_ready_e0", req_ready_b, 1'b0);
        chk_r("n1_eq_scale1_e0", sb1, 1.0, 0.0);
        tick();
        chk_b("n1_busy_e1", busy_b, 1'b0);
        chk_b("n1_done_e1", done_b, 1'b1);
        chk_r("n1_eq_scale2_e1", sb2, 1.0, 0.0);
        tick();
        chk_b("n1_done_e2", done_b, 1'b0);
        tb1 = 3.0; tb2 = -2.0; tb3 = 0.5; req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        chk_r("n1_hold_scale1", sb1, 1.0, 0.0);
        tick();
        chk_r("n1_scale1", sb1, 3.0, 0.0);
        chk_r("n1_scale2", sb2, -2.0, 0.0);
        chk_r("n1_scale3", sb3, 0.5, 0.0);
        chk_b("n1_done", done_b, 1'b1);

        @(negedge clk);
        #1;
        vectors++;
        if (q_s1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q_s1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwl_add3_gain_sched.md
PWL_ADD3_GAIN_SCHED -- requirements
Module: pwl_add3_gain_sched

Interface
REQ-001 SHALL have parameter NSTEP, default 8, meaning the number of clock edges per gain ramp; legal range 1..256; values outside the range SHALL stop elaboration with $fatal.
REQ-002 SHALL have parameter INIT1, default 1.0, meaning the reset value of scale1.
REQ-003 SHALL have parameter INIT2, default 1.0, meaning the reset value of scale2.
REQ-004 SHALL have parameter INIT3, default 1.0, meaning the reset value of scale3.
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: req_valid  input  1  a new target triplet is offered.
REQ-008 SHALL have port: req_ready  output  1  the block accepts a target this cycle.
REQ-009 SHALL have port: tgt1, tgt2, tgt3  input  real  target scale factors.
REQ-010 SHALL have port: freeze  input  1  pause the ramp and hold the adder output.
REQ-011 SHALL have port: abort  input  1  snap the scales to the targets immediately.
REQ-012 SHALL have port: scale1, scale2, scale3  output  real  drive the adder scale inputs.
REQ-013 SHALL have port: enable  output  1  drives the adder enable.
REQ-014 SHALL have port: busy  output  1  high while in RAMP.
REQ-015 SHALL have port: done  output  1  one-cycle pulse marking ramp completion.

Function
REQ-016 SHALL implement exactly two states, IDLE and RAMP.
REQ-017 req_ready SHALL equal (state==IDLE) && !freeze.
REQ-018 A transfer SHALL occur on a posedge where req_valid && req_ready are both high.
REQ-019 On a transfer, the block SHALL latch tgtk, compute stepk=(tgtk-scalek)/NSTEP for k=1..3, load cnt=NSTEP and enter RAMP.
REQ-020 On the transfer edge, the scale outputs SHALL remain unchanged.
REQ-021 In RAMP with freeze=0, each posedge SHALL apply scalek+=stepk and cnt-=1.
REQ-022 The RAMP edge where cnt==1 SHALL write scalek=latched tgtk exactly, with no accumulated rounding, and then return to IDLE.
REQ-023 Latency: a transfer at edge E0 SHALL give scale updates at E1..E_NSTEP, and the outputs SHALL equal the targets after E_NSTEP.
REQ-024 done SHALL be high for exactly the one cycle following the final RAMP edge, then return low.
REQ-025 req_ready SHALL go high at that same edge, unless freeze is high.
REQ-026 freeze=1 in RAMP SHALL hold the scales and cnt unchanged and SHALL not count as a step.
REQ-027 enable SHALL be !freeze, registered, in all states, so the adder output is held while frozen.
REQ-028 abort=1 in RAMP SHALL, on the next posedge, set scalek=latched tgtk, pulse done and return to IDLE, regardless of cnt.
REQ-029 abort=1 in IDLE SHALL be ignored.
REQ-030 When abort and freeze are high on the same edge, abort SHALL win; enable still SHALL follow freeze.
REQ-031 req_valid in RAMP SHALL be ignored, with no queuing; the requester SHALL hold req_valid until ready.
REQ-032 When tgtk equals the current scalek, stepk SHALL be 0 and the ramp SHALL still last NSTEP active edges and pulse done.
REQ-033 NSTEP=1 SHALL write the targets at E1 directly.
REQ-034 Target inputs SHALL be sampled only on the transfer edge; later changes SHALL not affect an ongoing ramp.
REQ-035 busy SHALL be high exactly when state==RAMP.

Reset
REQ-036 rstn low SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, scalek=INITk, enable=1, done=0, busy=0.
REQ-037 During reset, req_ready SHALL be 0.
REQ-038 Reset asserted mid-ramp SHALL discard the latched targets and steps.
REQ-039 After rstn deasserts, the first posedge SHALL operate normally: req_ready=1 if freeze=0.

Verification
REQ-040 NSTEP=4, defaults; transfer tgt=(2.0,0.0,-1.0) -> scale1 1.25/1.5/1.75/2.0, scale2 0.75/0.5/0.25/0.0, scale3 0.5/0.0/-0.5/-1.0 on E1..E4; done high one cycle after E4; busy high E1..E4.
REQ-041 Same ramp with freeze high for 3 cycles after E2 -> scales hold at 1.5/0.5/0.0; enable=0 for those cycles; completion delayed by exactly 3 edges; done once.
REQ-042 abort asserted after E1 -> next edge scales=(2.0,0.0,-1.0), done pulse, req_ready=1; cnt not exhausted.
REQ-043 rstn pulsed low mid-ramp (between clock edges) -> scales return to (1.0,1.0,1.0) without a clock edge; no done pulse; the next transfer ramps from 1.0.
REQ-044 req_valid held high through a ramp with a second target (0.5,0.5,0.5) -> accepted only on the edge req_ready returns high; the second ramp starts from (2.0,0.0,-1.0).
REQ-045 NSTEP=1 with tgt equal to the current scales -> a single busy cycle, scales unchanged, done pulsed.
